ps2_keycode_rx: RTL

//  PS/2 keyboard receiver feeding the player-motion stage (frog/ball controller) its 16-bit keycode.

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_frame_rx.sv | 135 +++++++++++++
 rtl/ps2_keycode_rx.sv | 92 +++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_frame_state_t;

  localparam logic [7:0]  PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0]  PS2_BRK_PREFIX = 8'hF0;
  localparam logic [15:0] KEY_NONE       = 16'h0000;

  // Full 16-bit keycode for a scan byte, with the extended prefix folded in.
  function automatic logic [15:0] make_code(input logic ext, input logic [7:0] scan);
    return {(ext ? PS2_EXT_PREFIX : 8'h00), scan};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, glitch-filters the clock,
// assembles 11-bit frames on falling edges and aborts stalled frames.
// byte_strobe_o / frame_err_o are single-cycle strobes aligned with the
// STOP-bit fall (or the timeout cycle); byte_data_o is valid with byte_strobe_o.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int CLK_FILTER_LEN = 8,
  parameter int TIMEOUT_CYC    = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_strobe_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int FW = $clog2(CLK_FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic             clk_meta_q, clk_sync_q;
  logic             data_meta_q, data_sync_q;
  logic             clk_filt_q;
  logic [FW-1:0]    filt_cnt_q;
  logic             fall_q;

  ps2_frame_state_t state_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic [TW-1:0]    to_cnt_q;

  logic             timeout_d;
  logic             frame_ok_d;
  logic             stop_fall_d;

  // Two-stage synchronizers; reset to the idle-high line level so no fall is
  // seen on reset release.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
    end
  end

  // Glitch filter: the filtered clock follows only after CLK_FILTER_LEN
  // consecutive differing samples; a 1->0 change raises the fall strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_sync_q != clk_filt_q) begin
        if (filt_cnt_q == FW'(CLK_FILTER_LEN - 1)) begin
          clk_filt_q <= clk_sync_q;
          filt_cnt_q <= '0;
          fall_q     <= clk_filt_q;
        end else begin
          filt_cnt_q <= filt_cnt_q + 1'b1;
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  // Stall detection and frame validity, evaluated every cycle.
  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    timeout_d   = 1'b0;
    stop_fall_d = 1'b0;
    frame_ok_d  = 1'b0;
    if (state_q != IDLE && !fall_q && to_cnt_q == TW'(TIMEOUT_CYC - 1))
      timeout_d = 1'b1;
    if (fall_q && state_q == STOP)
      stop_fall_d = 1'b1;
    // Stop bit is the data sampled at this fall; data+parity must be odd.
    if (data_sync_q && (^{parity_q, shift_q}))
      frame_ok_d = 1'b1;
  end

  assign byte_strobe_o = stop_fall_d && frame_ok_d;
  assign frame_err_o   = timeout_d || (stop_fall_d && !frame_ok_d);
  assign byte_data_o   = shift_q;

  // Frame FSM, stepped on fall strobes, with the mid-frame timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      if (state_q == IDLE || fall_q) to_cnt_q <= '0;
      else                           to_cnt_q <= to_cnt_q + 1'b1;

      if (timeout_d) begin
        state_q <= IDLE;
      end else if (fall_q) begin
        case (state_q)
          IDLE: begin
            bit_cnt_q <= '0;
            if (!data_sync_q) state_q <= DATA;
          end
          DATA: begin
            shift_q   <= {data_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            parity_q <= data_sync_q;
            state_q  <= STOP;
          end
          STOP:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver top: frame reception plus E0/F0 prefix tracking and
// held-key register feeding the motion stage.
// Optional build macro PS2_TYPEMATIC_FILTER_EN: when defined, a make equal to
// the currently held non-zero keycode does not pulse key_valid.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int CLK_FILTER_LEN = 8,
  parameter int TIMEOUT_CYC    = 50000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] keycode,
  output logic        key_valid,
  output logic        frame_err
);

  logic        rx_strobe;
  logic [7:0]  rx_byte;
  logic        rx_err;
  logic [15:0] code_d;

  logic [15:0] keycode_q;
  logic        key_valid_q;
  logic        frame_err_q;
  logic        ext_q;
  logic        brk_q;

  ps2_frame_rx #(
    .CLK_FILTER_LEN (CLK_FILTER_LEN),
    .TIMEOUT_CYC    (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk           (Clk),
    .rst_n         (Reset_n),
    .ps2_clk_i     (ps2_clk),
    .ps2_data_i    (ps2_data),
    .byte_strobe_o (rx_strobe),
    .byte_data_o   (rx_byte),
    .frame_err_o   (rx_err)
  );

  assign code_d = make_code(ext_q, rx_byte);

  // Prefix tracking and held-key update; errored frames drop any pending prefix.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      keycode_q   <= KEY_NONE;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      frame_err_q <= rx_err;
      if (rx_err) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (rx_strobe) begin
        if (rx_byte == PS2_EXT_PREFIX) begin
          ext_q <= 1'b1;
        end else if (rx_byte == PS2_BRK_PREFIX) begin
          brk_q <= 1'b1;
        end else begin
          if (!brk_q) begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            // Auto-repeat of the held key is swallowed.
            if (!(keycode_q != KEY_NONE && code_d == keycode_q)) begin
              keycode_q   <= code_d;
              key_valid_q <= 1'b1;
            end
`else
            keycode_q   <= code_d;
            key_valid_q <= 1'b1;
`endif
          end else if (keycode_q == code_d) begin
            // Only the release of the held key clears it.
            keycode_q <= KEY_NONE;
          end
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
    end
  end

  assign keycode   = keycode_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule
